// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state data memory.
// Holds the access-size and FSM state enums plus the bytes-per-word constant.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for one 32-bit little-endian memory word.
// Ports: i_size/i_off/i_uns/i_wdata/i_rword in; o_be, o_wdata, o_rdata, o_err out.
module mem_lane
    import mem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_off,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        unique case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_uns & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_err   = i_off[0];
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_uns & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_err   = |i_off;
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
        // A faulting access must neither write nor return data.
        if (o_err) begin
            o_be    = '0;
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with req/ready handshake and WAIT programmable wait states.
// Ports: clk, reset (async active-low), req/we/size/uns/addr/wdata in; rdata/ready/err out.
module dmem_wait
    import mem_pkg::*;
#(
    parameter int    DEPTH     = 64,
    parameter int    WAIT      = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    state_e        r_state;
    state_e        w_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    size_e         r_size;
    logic          r_uns;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_err;
    logic          w_perform;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdat;
    logic [31:0]   w_rdat;
    logic          w_err;
    logic          w_unused;

    // Address bits above the memory span wrap and are never used.
    assign w_unused = ^addr[31:AW+2];
    assign w_idx    = r_addr[AW+1:2];

    mem_lane u_lane (
        .i_size  (r_size),
        .i_off   (r_addr[1:0]),
        .i_uns   (r_uns),
        .i_wdata (r_wdata),
        .i_rword (r_mem[w_idx]),
        .o_be    (w_be),
        .o_wdata (w_wdat),
        .o_rdata (w_rdat),
        .o_err   (w_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_perform = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_perform = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_perform;
            if (r_state == IDLE && req) begin
                r_cnt   <= 4'(WAIT);
                r_we    <= we;
                r_size  <= size_e'(size);
                r_uns   <= uns;
                r_addr  <= addr[AW+1:0];
                r_wdata <= wdata;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_perform) begin
                r_rdata <= r_we ? 32'd0 : w_rdat;
                r_err   <= w_err;
            end
        end
    end

    // Memory contents survive reset; only the performing edge writes.
    always_ff @(posedge clk) begin
        if (w_perform && r_we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed self-checking bench for dmem_wait.
// Runs a WAIT=2 instance and a WAIT=0 instance on a shared clock and reset.
module tb_dmem_wait;

    logic        clk;
    logic        reset;
    logic        req;
    logic        req0;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata0;
    logic        ready;
    logic        ready0;
    logic        err;
    logic        err0;

    int tests;
    int fails;

    dmem_wait #(.DEPTH(64), .WAIT(2), .INIT_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .uns   (uns),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err)
    );

    dmem_wait #(.DEPTH(64), .WAIT(0), .INIT_FILE("")) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we),
        .size  (size),
        .uns   (uns),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One handshake: accept, count cycles to ready, check pulse width.
    task automatic acc(
        input  bit          s,
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        u,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        er,
        output int          lat
    );
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        if (s) req0 = 1'b1;
        else   req  = 1'b1;
        @(posedge clk);
        #1;
        req  = 1'b0;
        req0 = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((s ? ready0 : ready) === 1'b1) begin
                lat = i;
                break;
            end
        end
        rd = s ? rdata0 : rdata;
        er = s ? err0 : err;
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL timeout addr=%h: no ready within 20 cycles", a);
        end
        @(posedge clk);
        #1;
        tests++;
        if ((s ? ready0 : ready) !== 1'b0) begin
            fails++;
            $display("FAIL ready_width addr=%h: ready=%b want 0", a,
                     s ? ready0 : ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b0) begin
            fails++; $display("FAIL rst_ready got=%b want 0", ready);
        end
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL rst_err got=%b want 0", err);
        end
        tests++;
        if (rdata !== 32'd0) begin
            fails++; $display("FAIL rst_rdata got=%h want 0", rdata);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests++;
        if (lat != 3) begin
            fails++; $display("FAIL st_lat got=%0d want 3", lat);
        end
        tests++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            fails++; $display("FAIL st_resp got=%h/%b want 0/0", rd, er);
        end
        acc(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
        tests++;
        if (lat != 3) begin
            fails++; $display("FAIL ld_lat got=%0d want 3", lat);
        end
        tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            fails++;
            $display("FAIL ld_word got=%h/%b want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_bytes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(0, 1, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
        acc(0, 1, 2'b00, 0, 32'h21, 32'hFFFFFF80, rd, er, lat);
        acc(0, 1, 2'b00, 0, 32'h22, 32'h0000007F, rd, er, lat);
        acc(0, 0, 2'b00, 0, 32'h21, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'hFFFFFF80) begin
            fails++; $display("FAIL lb_s got=%h want ffffff80", rd);
        end
        acc(0, 0, 2'b00, 1, 32'h21, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h00000080) begin
            fails++; $display("FAIL lb_u got=%h want 00000080", rd);
        end
        acc(0, 0, 2'b01, 0, 32'h22, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h0000007F) begin
            fails++; $display("FAIL lh_s got=%h want 0000007f", rd);
        end
        acc(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h007F8000) begin
            fails++; $display("FAIL lw_bytes got=%h want 007f8000", rd);
        end
        acc(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, rd, er, lat);
        acc(0, 0, 2'b01, 0, 32'h22, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'hFFFFABCD) begin
            fails++; $display("FAIL lh_neg got=%h want ffffabcd", rd);
        end
        acc(0, 0, 2'b01, 1, 32'h22, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h0000ABCD) begin
            fails++; $display("FAIL lhu got=%h want 0000abcd", rd);
        end
    endtask

    task automatic test_err();
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(0, 1, 2'b10, 0, 32'h00, 32'h11223344, rd, er, lat);
        acc(0, 0, 2'b10, 0, 32'h02, 32'h0, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin
            fails++;
            $display("FAIL lw_mis got=%h/%b/%0d want 0/1/3", rd, er, lat);
        end
        acc(0, 1, 2'b01, 0, 32'h03, 32'hAAAAAAAA, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL sh_mis err=%b want 1", er);
        end
        acc(0, 1, 2'b11, 0, 32'h00, 32'h55555555, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++; $display("FAIL rsvd err=%b want 1", er);
        end
        acc(0, 0, 2'b10, 0, 32'h00, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            fails++;
            $display("FAIL err_nowr got=%h/%b want 11223344/0", rd, er);
        end
        acc(0, 0, 2'b00, 1, 32'h03, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h00000011 || er !== 1'b0) begin
            fails++;
            $display("FAIL lbu_b3 got=%h/%b want 00000011/0", rd, er);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(0, 1, 2'b10, 0, 32'h104, 32'h12345678, rd, er, lat);
        acc(0, 0, 2'b10, 0, 32'h004, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h12345678) begin
            fails++; $display("FAIL wrap got=%h want 12345678", rd);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(1, 1, 2'b10, 0, 32'h08, 32'hA5A5C3C3, rd, er, lat);
        tests++;
        if (lat != 1) begin
            fails++; $display("FAIL w0_st_lat got=%0d want 1", lat);
        end
        acc(1, 0, 2'b10, 0, 32'h08, 32'h0, rd, er, lat);
        tests++;
        if (lat != 1 || rd !== 32'hA5A5C3C3) begin
            fails++;
            $display("FAIL w0_ld got=%h/%0d want a5a5c3c3/1", rd, lat);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        acc(0, 1, 2'b10, 0, 32'h30, 32'h55AA55AA, rd, er, lat);
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0;
        addr = 32'h30; wdata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        reset = 1'b0;
        #2;
        tests++;
        if (ready !== 1'b0 || rdata !== 32'd0) begin
            fails++;
            $display("FAIL rst_busy_out got=%b/%h want 0/0", ready, rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL rst_busy_ready got=%0d want 0", seen);
        end
        acc(0, 0, 2'b10, 0, 32'h30, 32'h0, rd, er, lat);
        tests++;
        if (rd !== 32'h55AA55AA) begin
            fails++; $display("FAIL rst_busy_mem got=%h want 55aa55aa", rd);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        @(negedge clk);
        we = 1'b0; size = 2'b10; uns = 1'b0;
        addr = 32'h10; wdata = 32'h0; req = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen++;
        end
        @(negedge clk);
        req = 1'b0;
        tests++;
        if (seen != 4) begin
            fails++; $display("FAIL b2b_count got=%0d want 4", seen);
        end
        tests++;
        if (rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL b2b_data got=%h want deadbeef", rdata);
        end
        repeat (8) @(posedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        req   = 1'b0;
        req0  = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        uns   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        test_reset();
        test_word();
        test_bytes();
        test_err();
        test_wrap();
        test_wait0();
        test_reset_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
